// File: rtl/prefetch_responder_pkg.sv
// Shared widths, request encodings and FSM state type for the traceback prefetch responder.
package prefetch_responder_pkg;

    localparam int BP_WIDTH       = 2;
    localparam int POSITION_WIDTH = 10;
    localparam int PREFETCH_WIDTH = 5;
    localparam int SEQ_DEPTH      = 1024;

    localparam logic [1:0] PF_IDLE     = 2'b00;
    localparam logic [1:0] PF_CURRENT  = 2'b01;
    localparam logic [1:0] PF_PREFETCH = 2'b10;
    localparam logic [1:0] PF_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } pf_state_t;

endpackage

// File: rtl/prefetch_responder_if.sv
// Bundle of sequence-load, prefetch-request and beat-stream signals around prefetch_responder.
interface prefetch_responder_if
    import prefetch_responder_pkg::*;
#(
    parameter int BP_W  = BP_WIDTH,
    parameter int POS_W = POSITION_WIDTH,
    parameter int PF_W  = PREFETCH_WIDTH
);
    logic             seq_wr_en;
    logic             seq_wr_sel;
    logic [POS_W-1:0] seq_wr_addr;
    logic [BP_W-1:0]  seq_wr_data;

    logic [1:0]       prefetch_request;
    logic [POS_W-1:0] in_block_x_startpoint;
    logic [POS_W-1:0] in_block_y_startpoint;
    logic [POS_W-1:0] prefetch_x_startpoint;
    logic [POS_W-1:0] prefetch_y_startpoint;

    logic             pf_valid;
    logic [BP_W-1:0]  pf_s;
    logic [BP_W-1:0]  pf_t;
    logic [PF_W-1:0]  pf_index;
    logic             pf_target;
    logic             pf_last;
    logic             pf_pad_s;
    logic             pf_pad_t;
    logic             pf_busy;
    logic             err_overrun;
    logic             err_illegal;

    modport master (
        output seq_wr_en, seq_wr_sel, seq_wr_addr, seq_wr_data,
        output prefetch_request, in_block_x_startpoint, in_block_y_startpoint,
        output prefetch_x_startpoint, prefetch_y_startpoint,
        input  pf_valid, pf_s, pf_t, pf_index, pf_target, pf_last,
        input  pf_pad_s, pf_pad_t, pf_busy, err_overrun, err_illegal
    );

    modport slave (
        input  seq_wr_en, seq_wr_sel, seq_wr_addr, seq_wr_data,
        input  prefetch_request, in_block_x_startpoint, in_block_y_startpoint,
        input  prefetch_x_startpoint, prefetch_y_startpoint,
        output pf_valid, pf_s, pf_t, pf_index, pf_target, pf_last,
        output pf_pad_s, pf_pad_t, pf_busy, err_overrun, err_illegal
    );
endinterface

// File: rtl/prefetch_responder_seq_ram.sv
// Single-write, synchronous read-first sequence RAM; output register clears when no read is issued.
module seq_ram #(
    parameter int BP_WIDTH = 2,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024
) (
    input  logic                clk,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [BP_WIDTH-1:0] i_wr_data,
    input  logic                i_rd_en,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [BP_WIDTH-1:0] o_rd_data
);
    logic [BP_WIDTH-1:0] r_mem [DEPTH];
    logic [BP_WIDTH-1:0] r_rd_data_p1;

    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // Read stage: old contents win on a same-address write.
    always_ff @(posedge clk) begin
        r_rd_data_p1 <= i_rd_en ? r_mem[i_rd_addr] : '0;
    end

    assign o_rd_data = r_rd_data_p1;
endmodule

// File: rtl/prefetch_responder.sv
// Streams 32 S/T base pairs walking up-left from a requested start point.
// Optional feature: define PREFETCH_PAD_EN to pad negative positions instead of wrapping.
module prefetch_responder
    import prefetch_responder_pkg::*;
#(
    parameter int BP_W   = BP_WIDTH,
    parameter int POS_W  = POSITION_WIDTH,
    parameter int PF_W   = PREFETCH_WIDTH,
    parameter int DEPTH  = SEQ_DEPTH
) (
    input  logic              clk,
    input  logic              reset_i,
    prefetch_responder_if.slave bus
);
    localparam int AW = POS_W + 1;
    localparam logic signed [AW:0] DEPTH_S = (AW+1)'(DEPTH);

    pf_state_t          r_state;
    logic [PF_W-1:0]    r_k;
    logic [POS_W-1:0]   r_x;
    logic [POS_W-1:0]   r_y;
    logic               r_target;
    logic               r_busy;
    logic               r_vld_p1;
    logic [PF_W-1:0]    r_index_p1;
    logic               r_last_p1;
    logic               r_pad_s_p1;
    logic               r_pad_t_p1;
    logic               r_err_overrun;
    logic               r_err_illegal;

    logic signed [AW-1:0] w_pos_x;
    logic signed [AW-1:0] w_pos_y;
    logic                 w_reading;
    logic                 w_pad_s;
    logic                 w_pad_t;
    logic                 w_rd_en_s;
    logic                 w_rd_en_t;
    logic [BP_W-1:0]      w_s_q;
    logic [BP_W-1:0]      w_t_q;

    // Negative positions fold back to the top of the sequence.
    function automatic logic [POS_W-1:0] wrap_addr(input logic signed [AW-1:0] pos);
        logic signed [AW:0] w_ext;
        w_ext = (AW+1)'(pos);
        if (pos < 0) w_ext = w_ext + DEPTH_S;
        return w_ext[POS_W-1:0];
    endfunction

    assign w_pos_x   = $signed({1'b0, r_x}) - $signed({{(AW-PF_W){1'b0}}, r_k});
    assign w_pos_y   = $signed({1'b0, r_y}) - $signed({{(AW-PF_W){1'b0}}, r_k});
    assign w_reading = (r_state == ST_READ) && !reset_i;

`ifdef PREFETCH_PAD_EN
    assign w_pad_s   = w_pos_x[AW-1];
    assign w_pad_t   = w_pos_y[AW-1];
`else
    assign w_pad_s   = 1'b0;
    assign w_pad_t   = 1'b0;
`endif
    assign w_rd_en_s = w_reading && !w_pad_s;
    assign w_rd_en_t = w_reading && !w_pad_t;

    seq_ram #(.BP_WIDTH(BP_W), .ADDR_W(POS_W), .DEPTH(DEPTH)) u_ram_s (
        .clk       (clk),
        .i_wr_en   (bus.seq_wr_en && !bus.seq_wr_sel),
        .i_wr_addr (bus.seq_wr_addr),
        .i_wr_data (bus.seq_wr_data),
        .i_rd_en   (w_rd_en_s),
        .i_rd_addr (wrap_addr(w_pos_x)),
        .o_rd_data (w_s_q)
    );

    seq_ram #(.BP_WIDTH(BP_W), .ADDR_W(POS_W), .DEPTH(DEPTH)) u_ram_t (
        .clk       (clk),
        .i_wr_en   (bus.seq_wr_en && bus.seq_wr_sel),
        .i_wr_addr (bus.seq_wr_addr),
        .i_wr_data (bus.seq_wr_data),
        .i_rd_en   (w_rd_en_t),
        .i_rd_addr (wrap_addr(w_pos_y)),
        .o_rd_data (w_t_q)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state       <= ST_IDLE;
            r_k           <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_target      <= 1'b0;
            r_busy        <= 1'b0;
            r_vld_p1      <= 1'b0;
            r_index_p1    <= '0;
            r_last_p1     <= 1'b0;
            r_pad_s_p1    <= 1'b0;
            r_pad_t_p1    <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_illegal <= 1'b0;
        end else begin
            // Beat stage: tags line up with the RAM data read this cycle.
            r_vld_p1   <= (r_state == ST_READ);
            r_index_p1 <= (r_state == ST_READ) ? ~r_k : '0;
            r_last_p1  <= (r_state == ST_READ) && (&r_k);
            r_pad_s_p1 <= (r_state == ST_READ) && w_pad_s;
            r_pad_t_p1 <= (r_state == ST_READ) && w_pad_t;

            case (r_state)
                ST_IDLE: begin
                    case (bus.prefetch_request)
                        PF_CURRENT: begin
                            r_x      <= bus.in_block_x_startpoint;
                            r_y      <= bus.in_block_y_startpoint;
                            r_target <= 1'b0;
                            r_k      <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_READ;
                        end
                        PF_PREFETCH: begin
                            r_x      <= bus.prefetch_x_startpoint;
                            r_y      <= bus.prefetch_y_startpoint;
                            r_target <= 1'b1;
                            r_k      <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_READ;
                        end
                        PF_ILLEGAL: r_err_illegal <= 1'b1;
                        default: ;
                    endcase
                end
                ST_READ: begin
                    r_k <= r_k + 1'b1;
                    if (&r_k) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            if ((r_state != ST_IDLE) && (bus.prefetch_request != PF_IDLE))
                r_err_overrun <= 1'b1;
        end
    end

    assign bus.pf_valid    = r_vld_p1;
    assign bus.pf_s        = w_s_q;
    assign bus.pf_t        = w_t_q;
    assign bus.pf_index    = r_index_p1;
    assign bus.pf_target   = r_target;
    assign bus.pf_last     = r_last_p1;
    assign bus.pf_pad_s    = r_pad_s_p1;
    assign bus.pf_pad_t    = r_pad_t_p1;
    assign bus.pf_busy     = r_busy;
    assign bus.err_overrun = r_err_overrun;
    assign bus.err_illegal = r_err_illegal;
endmodule
